vga_box_compositor: RTL

//  Parametrised multi-box sprite overlay for the 640x480 VGA pipeline; generalises single player/target box drawing to NUM_BOXES boxes.

---
 rtl/vga_box_compositor.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/vga_box_compositor.sv
// Multi-box sprite overlay with frame-synchronous double-buffered geometry and box0 overlap report.
// Optional VGA_BOX_BORDER_EN: draws an inverted-colour rim BORDER_W pixels thick on every box.

module vga_box_lane #(
  parameter int X_WIDTH    = 10,
  parameter int Y_WIDTH    = 9,
  parameter int HALF_WIDTH = 8,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int BORDER_W   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [X_WIDTH-1:0]    cx,
  input  logic [Y_WIDTH-1:0]    cy,
  input  logic [HALF_WIDTH-1:0] half,
  input  logic [X_WIDTH-1:0]    x,
  input  logic [Y_WIDTH-1:0]    y,
  output logic                  hit,
  output logic                  border
);
  localparam logic [X_WIDTH:0] X_LIM = (X_WIDTH+1)'(H_ACTIVE);
  localparam logic [Y_WIDTH:0] Y_LIM = (Y_WIDTH+1)'(V_ACTIVE);

  logic [X_WIDTH:0]   hx, xs;
  logic [Y_WIDTH:0]   hy, ys;
  logic [X_WIDTH-1:0] left_d, left_q, right_d, right_q;
  logic [Y_WIDTH-1:0] top_d, top_q, bot_d, bot_q;
  logic               vis_d, vis_q;

  // One extra bit on every sum/compare so edges clamp instead of wrapping.
  always_comb begin
    hx      = (X_WIDTH+1)'(half);
    hy      = (Y_WIDTH+1)'(half);
    xs      = {1'b0, cx} + hx;
    ys      = {1'b0, cy} + hy;
    left_d  = ({1'b0, cx} < hx) ? '0 : X_WIDTH'({1'b0, cx} - hx);
    top_d   = ({1'b0, cy} < hy) ? '0 : Y_WIDTH'({1'b0, cy} - hy);
    right_d = (xs > X_LIM - 1'b1) ? X_WIDTH'(X_LIM - 1'b1) : X_WIDTH'(xs);
    bot_d   = (ys > Y_LIM - 1'b1) ? Y_WIDTH'(Y_LIM - 1'b1) : Y_WIDTH'(ys);
    vis_d   = en & ({1'b0, cx} < X_LIM) & ({1'b0, cy} < Y_LIM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_q  <= '0;
      right_q <= '0;
      top_q   <= '0;
      bot_q   <= '0;
      vis_q   <= 1'b0;
    end else begin
      left_q  <= left_d;
      right_q <= right_d;
      top_q   <= top_d;
      bot_q   <= bot_d;
      vis_q   <= vis_d;
    end
  end

  assign hit = vis_q & (x >= left_q) & (x <= right_q) & (y >= top_q) & (y <= bot_q);

`ifdef VGA_BOX_BORDER_EN
  // Only meaningful while hit, so x-left and right-x never underflow where used.
  assign border = ((x - left_q) < X_WIDTH'(BORDER_W)) | ((right_q - x) < X_WIDTH'(BORDER_W)) |
                  ((y - top_q)  < Y_WIDTH'(BORDER_W)) | ((bot_q - y)   < Y_WIDTH'(BORDER_W));
`else
  assign border = 1'b0;
`endif
endmodule

module vga_box_compositor #(
  parameter int NUM_BOXES  = 4,
  parameter int X_WIDTH    = 10,
  parameter int Y_WIDTH    = 9,
  parameter int HALF_WIDTH = 8,
  parameter int COLOR_BITS = 12,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int BG_LATENCY = 2,
  parameter int BORDER_W   = 2
) (
  input  logic                             clk_25mHz,
  input  logic                             reset,
  input  logic                             active_in,
  input  logic                             screen_end,
  input  logic [X_WIDTH-1:0]               x_in,
  input  logic [Y_WIDTH-1:0]               y_in,
  input  logic [COLOR_BITS-1:0]            bg_color,
  input  logic                             bg_blank,
  input  logic [NUM_BOXES-1:0]             box_en,
  input  logic [NUM_BOXES*X_WIDTH-1:0]     box_cx,
  input  logic [NUM_BOXES*Y_WIDTH-1:0]     box_cy,
  input  logic [NUM_BOXES*HALF_WIDTH-1:0]  box_half,
  input  logic [NUM_BOXES*COLOR_BITS-1:0]  box_color,
  output logic [COLOR_BITS-1:0]            color_out,
  output logic                             active_out,
  output logic [NUM_BOXES-1:0]             hit_mask,
  output logic [NUM_BOXES-1:0]             overlap,
  output logic                             overlap_valid
);
  logic                                  se_q, se_rise;
  logic [NUM_BOXES-1:0]                  en_d, en_q;
  logic [NUM_BOXES-1:0][X_WIDTH-1:0]     cx_d, cx_q;
  logic [NUM_BOXES-1:0][Y_WIDTH-1:0]     cy_d, cy_q;
  logic [NUM_BOXES-1:0][HALF_WIDTH-1:0]  half_d, half_q;
  logic [NUM_BOXES-1:0][COLOR_BITS-1:0]  col_d, col_q;
  logic [BG_LATENCY-1:0][X_WIDTH-1:0]    x_pipe_d, x_pipe_q;
  logic [BG_LATENCY-1:0][Y_WIDTH-1:0]    y_pipe_d, y_pipe_q;
  logic [BG_LATENCY-1:0]                 act_pipe_d, act_pipe_q;
  logic [NUM_BOXES-1:0]                  hit, border;
  logic [COLOR_BITS-1:0]                 color_d, color_q;
  logic                                  active_d, active_q;
  logic [NUM_BOXES-1:0]                  hit_d, hit_q, term;
  logic [NUM_BOXES-1:0]                  acc_d, acc_q, overlap_d, overlap_q;
  logic                                  ovl_vld_d, ovl_vld_q;

  assign se_rise = screen_end & ~se_q;

  genvar g;
  generate
    for (g = 0; g < NUM_BOXES; g++) begin : g_lane
      vga_box_lane #(
        .X_WIDTH(X_WIDTH), .Y_WIDTH(Y_WIDTH), .HALF_WIDTH(HALF_WIDTH),
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .BORDER_W(BORDER_W)
      ) u_lane (
        .clk(clk_25mHz), .rst(reset), .en(en_q[g]), .cx(cx_q[g]), .cy(cy_q[g]),
        .half(half_q[g]), .x(x_pipe_q[BG_LATENCY-1]), .y(y_pipe_q[BG_LATENCY-1]),
        .hit(hit[g]), .border(border[g])
      );
    end
  endgenerate

  always_comb begin
    en_d   = en_q;
    cx_d   = cx_q;
    cy_d   = cy_q;
    half_d = half_q;
    col_d  = col_q;
    if (se_rise) begin
      en_d = box_en;
      for (int i = 0; i < NUM_BOXES; i++) begin
        cx_d[i]   = box_cx[i*X_WIDTH +: X_WIDTH];
        cy_d[i]   = box_cy[i*Y_WIDTH +: Y_WIDTH];
        half_d[i] = box_half[i*HALF_WIDTH +: HALF_WIDTH];
        col_d[i]  = box_color[i*COLOR_BITS +: COLOR_BITS];
      end
    end

    x_pipe_d[0]   = x_in;
    y_pipe_d[0]   = y_in;
    act_pipe_d[0] = active_in;
    for (int i = 1; i < BG_LATENCY; i++) begin
      x_pipe_d[i]   = x_pipe_q[i-1];
      y_pipe_d[i]   = y_pipe_q[i-1];
      act_pipe_d[i] = act_pipe_q[i-1];
    end

    // Walk from lowest priority up so box 0 overwrites last.
    color_d = bg_blank ? '0 : bg_color;
    for (int i = NUM_BOXES-1; i >= 0; i--)
      if (hit[i]) color_d = border[i] ? ~col_q[i] : col_q[i];
    if (!act_pipe_q[BG_LATENCY-1]) color_d = '0;
    active_d = act_pipe_q[BG_LATENCY-1];
    hit_d    = hit;

    term      = (hit_q[0] && active_q) ? hit_q : '0;
    term[0]   = 1'b0;
    acc_d     = se_rise ? '0 : (acc_q | term);
    overlap_d = se_rise ? (acc_q | term) : overlap_q;
    ovl_vld_d = se_rise;
  end

  always_ff @(posedge clk_25mHz or posedge reset) begin
    if (reset) begin
      se_q       <= 1'b0;
      en_q       <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      half_q     <= '0;
      col_q      <= '0;
      x_pipe_q   <= '0;
      y_pipe_q   <= '0;
      act_pipe_q <= '0;
      color_q    <= '0;
      active_q   <= 1'b0;
      hit_q      <= '0;
      acc_q      <= '0;
      overlap_q  <= '0;
      ovl_vld_q  <= 1'b0;
    end else begin
      se_q       <= screen_end;
      en_q       <= en_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      half_q     <= half_d;
      col_q      <= col_d;
      x_pipe_q   <= x_pipe_d;
      y_pipe_q   <= y_pipe_d;
      act_pipe_q <= act_pipe_d;
      color_q    <= color_d;
      active_q   <= active_d;
      hit_q      <= hit_d;
      acc_q      <= acc_d;
      overlap_q  <= overlap_d;
      ovl_vld_q  <= ovl_vld_d;
    end
  end

  assign color_out     = color_q;
  assign active_out    = active_q;
  assign hit_mask      = hit_q;
  assign overlap       = overlap_q;
  assign overlap_valid = ovl_vld_q;
endmodule
